// File: rtl/dmem_param_if.sv
// dmem_param_if -- request/response bus of the dmem_param data memory.
//   master : drives req_valid, req_we, req_be, req_addr, req_wdata;
//            observes req_ready, rsp_valid, rsp_rdata, rsp_err.
//   slave  : the memory side (mirror of master).
// DATA_W and ADDR_W must match the parameters of the attached dmem_param.
interface dmem_param_if #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 16
) ();
  logic                  req_valid;
  logic                  req_ready;
  logic                  req_we;
  logic [DATA_W/8-1:0]   req_be;
  logic [ADDR_W-1:0]     req_addr;
  logic [DATA_W-1:0]     req_wdata;
  logic                  rsp_valid;
  logic [DATA_W-1:0]     rsp_rdata;
  logic                  rsp_err;

  modport master (
    output req_valid, req_we, req_be, req_addr, req_wdata,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err
  );

  modport slave (
    input  req_valid, req_we, req_be, req_addr, req_wdata,
    output req_ready, rsp_valid, rsp_rdata, rsp_err
  );
endinterface

// File: rtl/dmem_param.sv
// dmem_param -- single-port word memory with byte-lane writes, 1-cycle
// response latency and one request per cycle throughput.
//   clk       : single clock, rising edge
//   rst_n     : asynchronous active-low reset
//   bus       : dmem_param_if.slave (request handshake + response pulse)
//   init_done : memory initialised and usable
// Optional feature: define DMEM_INIT_CLEAR_EN to sweep zeros into every word
// after reset (INIT state, one word per cycle) before accepting requests.
// Without it the block starts in RUN and memory is unspecified until written.
module dmem_param #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 16,
  parameter int DEPTH  = 1024
) (
  input  logic         clk,
  input  logic         rst_n,
  dmem_param_if.slave  bus,
  output logic         init_done
);

  localparam int NB    = DATA_W / 8;
  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  localparam logic [0:0] ST_INIT = 1'b0;
  localparam logic [0:0] ST_RUN  = 1'b1;
`ifdef DMEM_INIT_CLEAR_EN
  localparam logic [0:0] ST_RESET = ST_INIT;
`else
  localparam logic [0:0] ST_RESET = ST_RUN;
`endif

  logic [0:0]        state;
  logic [IDX_W-1:0]  sweep_cnt;
  logic [DATA_W-1:0] mem [DEPTH];

  logic              accept;
  logic              in_range;
  logic [IDX_W-1:0]  idx;

  logic              rsp_valid_q;
  logic [DATA_W-1:0] rsp_rdata_q;
  logic              rsp_err_q;

  // One extra bit so DEPTH == 2**ADDR_W is representable in the compare.
  assign in_range = ({1'b0, bus.req_addr} < (ADDR_W+1)'(DEPTH));
  assign idx      = bus.req_addr[IDX_W-1:0];

  assign bus.req_ready = (state == ST_RUN);
  assign init_done     = (state == ST_RUN);
  assign accept        = bus.req_valid && bus.req_ready;

  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_rdata = rsp_rdata_q;
  assign bus.rsp_err   = rsp_err_q;

  // Control state and clear-sweep counter. In the default build the reset
  // state is RUN and the INIT branch is never reached.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_RESET;
      sweep_cnt <= '0;
    end else if (state == ST_INIT) begin
      if (sweep_cnt == IDX_W'(DEPTH - 1)) begin
        state <= ST_RUN;
      end
      sweep_cnt <= sweep_cnt + IDX_W'(1);
    end
  end

  // Storage array: deliberately not reset. Sweep writes and request writes
  // are mutually exclusive because requests are only accepted in RUN.
  always_ff @(posedge clk) begin
    if (state == ST_INIT) begin
      mem[sweep_cnt] <= '0;
    end else if (accept && bus.req_we && in_range) begin
      for (int unsigned i = 0; i < NB; i++) begin
        if (bus.req_be[i]) begin
          mem[idx][8*i +: 8] <= bus.req_wdata[8*i +: 8];
        end
      end
    end
  end

  // Response register: the read samples mem before this edge's write lands,
  // so a read in the cycle after a write naturally sees the new data.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
    end else if (accept) begin
      rsp_valid_q <= 1'b1;
      rsp_err_q   <= !in_range;
      rsp_rdata_q <= (in_range && !bus.req_we) ? mem[idx] : '0;
    end else begin
      rsp_valid_q <= 1'b0;
    end
  end

endmodule
